// File: rtl/pueo_evbuild_pkg.sv
// rtl/pueo_evbuild_pkg.sv - shared types and widths for the trigger event builder
package pueo_evbuild_pkg;

  localparam int unsigned TS_BITS    = 32;
  localparam int unsigned EVNUM_BITS = 32;
  localparam int unsigned META_BITS  = 64;
  localparam int unsigned REC_BEATS  = 5;
  localparam int unsigned REC_BITS   = REC_BEATS * META_BITS;

  typedef enum logic [2:0] {
    BEAT_IDLE,
    BEAT_HDR,
    BEAT_M0,
    BEAT_M1,
    BEAT_M2,
    BEAT_M3
  } beat_e;

  typedef struct packed {
    logic [EVNUM_BITS-1:0]         evnum;
    logic [TS_BITS-1:0]            timestamp;
    logic [3:0][META_BITS-1:0]     meta;
  } evrec_t;

endpackage

// File: rtl/pueo_evbuild_fifo.sv
// rtl/pueo_evbuild_fifo.sv - first-word fall-through record FIFO
// Writes while full are discarded; full/empty reflect the state before this clock's pop.
module pueo_evbuild_fifo
  import pueo_evbuild_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  evrec_t              wr_data_i,
  input  logic                rd_en_i,
  output evrec_t              rd_data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [REC_BITS-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_wr;
  logic                  do_rd;

  assign full_o    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign count_o   = count_q;
  assign rd_data_o = evrec_t'(mem_q[rd_ptr_q]);

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_q + (DEPTH_LOG2+1)'(do_wr) - (DEPTH_LOG2+1)'(do_rd);
    end
  end

endmodule

// File: rtl/pueo_trig_event_builder.sv
// rtl/pueo_trig_event_builder.sv - stamps triggers, buffers records, streams 5-beat events
// Also returns holdoff/dead to the upstream trigger block.
module pueo_trig_event_builder
  import pueo_evbuild_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned HOLDOFF_BITS    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  input  logic                    run_i,
  input  logic                    trig_i,
  input  logic [63:0]             tio0_meta_i,
  input  logic [63:0]             tio1_meta_i,
  input  logic [63:0]             tio2_meta_i,
  input  logic [63:0]             tio3_meta_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_len_i,
  output logic                    holdoff_o,
  output logic                    dead_o,
  output logic [15:0]             overflow_o,
  output logic [63:0]             m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic                   run_q;
  logic [TS_BITS-1:0]     ts_q;
  logic [EVNUM_BITS-1:0]  evnum_q;
  logic                   hold_q;
  logic [HOLDOFF_BITS-1:0] hold_cnt_q;
  logic                   dead_q;
  logic [15:0]            ovf_q;
  beat_e                  state_q, state_d;

  logic                   run_rise;
  logic                   trig_run;
  logic                   fifo_wr;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  evrec_t                 wr_rec;
  evrec_t                 head_rec;

  assign run_rise = run_i & ~run_q;
  assign trig_run = trig_i & run_i;
  assign fifo_wr  = trig_run & ~fifo_full;

  assign wr_rec.evnum     = evnum_q;
  assign wr_rec.timestamp = ts_q;
  assign wr_rec.meta[0]   = tio0_meta_i;
  assign wr_rec.meta[1]   = tio1_meta_i;
  assign wr_rec.meta[2]   = tio2_meta_i;
  assign wr_rec.meta[3]   = tio3_meta_i;

  pueo_evbuild_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (fifo_wr),
    .wr_data_i (wr_rec),
    .rd_en_i   (fifo_pop),
    .rd_data_o (head_rec),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // A run rising edge wins over a coincident ce tick so the first stamp after start is 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q   <= 1'b0;
      ts_q    <= '0;
      evnum_q <= '0;
    end else begin
      run_q <= run_i;
      if (run_rise) begin
        ts_q    <= '0;
        evnum_q <= '0;
      end else if (run_i) begin
        if (ce_i)   ts_q    <= ts_q + TS_BITS'(1);
        if (trig_i) evnum_q <= evnum_q + EVNUM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else if (trig_run) begin
      hold_q     <= 1'b1;
      hold_cnt_q <= (holdoff_len_i == '0) ? HOLDOFF_BITS'(1) : holdoff_len_i;
    end else if (hold_q && ce_i) begin
      hold_cnt_q <= hold_cnt_q - HOLDOFF_BITS'(1);
      if (hold_cnt_q == HOLDOFF_BITS'(1)) hold_q <= 1'b0;
    end
  end

  // Two-slot margin absorbs the trigger path latency before the FIFO really fills.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dead_q <= 1'b1;
      ovf_q  <= '0;
    end else begin
      dead_q <= ~run_i | (fifo_count >= (FIFO_DEPTH_LOG2+1)'(DEPTH - 2));
      if (trig_run && fifo_full && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BEAT_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      BEAT_IDLE: if (!fifo_empty) state_d = BEAT_HDR;
      BEAT_HDR:  if (m_tready) state_d = BEAT_M0;
      BEAT_M0:   if (m_tready) state_d = BEAT_M1;
      BEAT_M1:   if (m_tready) state_d = BEAT_M2;
      BEAT_M2:   if (m_tready) state_d = BEAT_M3;
      BEAT_M3: begin
        if (m_tready) begin
          fifo_pop = 1'b1;
          state_d  = ((fifo_count > (FIFO_DEPTH_LOG2+1)'(1)) || fifo_wr) ? BEAT_HDR : BEAT_IDLE;
        end
      end
      default:   state_d = BEAT_IDLE;
    endcase
  end

  always_comb begin
    m_tdata = '0;
    case (state_q)
      BEAT_HDR: m_tdata = {head_rec.evnum, head_rec.timestamp};
      BEAT_M0:  m_tdata = head_rec.meta[0];
      BEAT_M1:  m_tdata = head_rec.meta[1];
      BEAT_M2:  m_tdata = head_rec.meta[2];
      BEAT_M3:  m_tdata = head_rec.meta[3];
      default:  m_tdata = '0;
    endcase
  end

  assign m_tvalid   = (state_q != BEAT_IDLE);
  assign m_tlast    = (state_q == BEAT_M3);
  assign holdoff_o  = hold_q;
  assign dead_o     = dead_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pueo_trig_event_builder.sv
// tb/tb_pueo_trig_event_builder.sv - self-checking bench for pueo_trig_event_builder
module tb_pueo_trig_event_builder;

  logic        clk = 1'b0;
  logic        rst_i, ce_i, run_i, trig_i, m_tready;
  logic [63:0] meta_v [4];
  logic [15:0] holdoff_len;
  logic        holdoff_o, dead_o, m_tvalid, m_tlast;
  logic [15:0] overflow_o;
  logic [63:0] m_tdata;

  int nvec = 0;
  int nerr = 0;
  int ce_mode = 0;
  bit ce_phase = 1'b0;
  bit rand_ready = 1'b0;

  logic [64:0] sb [$];
  logic [64:0] obs [$];
  int          m_cnt = 0;
  int          ov_m = 0;
  logic [31:0] ts_m = '0;
  logic [31:0] ev_m = '0;
  bit          run_prev = 1'b0;
  bit          stall = 1'b0;
  logic [63:0] held = '0;

  pueo_trig_event_builder #(
    .FIFO_DEPTH_LOG2 (4),
    .HOLDOFF_BITS    (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ce_i          (ce_i),
    .run_i         (run_i),
    .trig_i        (trig_i),
    .tio0_meta_i   (meta_v[0]),
    .tio1_meta_i   (meta_v[1]),
    .tio2_meta_i   (meta_v[2]),
    .tio3_meta_i   (meta_v[3]),
    .holdoff_len_i (holdoff_len),
    .holdoff_o     (holdoff_o),
    .dead_o        (dead_o),
    .overflow_o    (overflow_o),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast)
  );

  always #5 clk = ~clk;

  // Reference model: everything seen at the falling edge describes the coming rising edge.
  always @(negedge clk) begin
    logic [64:0] e;
    bit pop;
    if (rst_i) begin
      sb.delete();
      m_cnt = 0; ov_m = 0; ts_m = '0; ev_m = '0;
      run_prev = 1'b0; stall = 1'b0;
    end else begin
      if (stall) begin
        nvec++;
        if (m_tvalid !== 1'b1 || m_tdata !== held) begin
          nerr++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", m_tvalid, m_tdata, held);
        end
      end
      pop = 1'b0;
      if (m_tvalid && m_tready) begin
        obs.push_back({m_tlast, m_tdata});
        nvec++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_beat: got %h expected no beat", {m_tlast, m_tdata});
        end else begin
          e = sb.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            nerr++;
            $display("FAIL beat: got %h expected %h", {m_tlast, m_tdata}, e);
          end
        end
        pop = m_tlast;
      end
      stall = m_tvalid && !m_tready;
      held  = m_tdata;
      if (trig_i && run_i) begin
        if (m_cnt == 16) begin
          if (ov_m < 65535) ov_m++;
        end else begin
          sb.push_back({1'b0, ev_m, ts_m});
          sb.push_back({1'b0, meta_v[0]});
          sb.push_back({1'b0, meta_v[1]});
          sb.push_back({1'b0, meta_v[2]});
          sb.push_back({1'b1, meta_v[3]});
          m_cnt++;
        end
      end
      if (pop) m_cnt--;
      if (run_i && !run_prev) begin
        ts_m = '0; ev_m = '0;
      end else if (run_i) begin
        if (ce_i)   ts_m = ts_m + 1;
        if (trig_i) ev_m = ev_m + 1;
      end
      run_prev = run_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    trig_i   = 1'b0;
    ce_phase = ~ce_phase;
    case (ce_mode)
      0:       ce_i = 1'b1;
      1:       ce_i = ce_phase;
      default: ce_i = 1'($urandom_range(0, 1));
    endcase
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic fire(input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [63:0] d);
    int g = 0;
    while (!ce_i && g < 50) begin
      step();
      g++;
    end
    ce_i = 1'b1;
    trig_i = 1'b1;
    meta_v[0] = a; meta_v[1] = b; meta_v[2] = c; meta_v[3] = d;
    step();
  endtask

  task automatic fire_rand();
    fire({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic wait_obs(input int n, input string name);
    int k = 0;
    while (obs.size() < n && k < 400) begin
      step();
      k++;
    end
    nvec++;
    if (obs.size() < n) begin
      nerr++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", name, obs.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) step();
    nvec++;
    if ({holdoff_o, dead_o, overflow_o, m_tvalid, m_tlast, m_tdata} !== {1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 64'd0}) begin
      nerr++;
      $display("FAIL reset_state: got hold=%b dead=%b ovf=%h valid=%b last=%b data=%h expected 0 1 0000 0 0 0",
               holdoff_o, dead_o, overflow_o, m_tvalid, m_tlast, m_tdata);
    end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single();
    obs.delete();
    ce_mode = 0; m_tready = 1'b1;
    run_i = 1'b1;
    repeat (101) step();
    fire(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
         64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    nvec++;
    if (m_tvalid !== 1'b0) begin
      nerr++;
      $display("FAIL latency_early: got valid=%b expected 0", m_tvalid);
    end
    step();
    nvec++;
    if (m_tvalid !== 1'b1 || m_tdata !== {32'd0, 32'd100}) begin
      nerr++;
      $display("FAIL latency_hdr: got valid=%b data=%h expected 1 %h", m_tvalid, m_tdata, {32'd0, 32'd100});
    end
    wait_obs(5, "single");
    if (obs.size() >= 5) begin
      logic [64:0] exp_b [5];
      exp_b[0] = {1'b0, 32'd0, 32'd100};
      exp_b[1] = {1'b0, 64'h1111_1111_1111_1111};
      exp_b[2] = {1'b0, 64'h2222_2222_2222_2222};
      exp_b[3] = {1'b0, 64'h3333_3333_3333_3333};
      exp_b[4] = {1'b1, 64'h4444_4444_4444_4444};
      for (int i = 0; i < 5; i++) begin
        nvec++;
        if (obs[i] !== exp_b[i]) begin
          nerr++;
          $display("FAIL single_beat%0d: got %h expected %h", i, obs[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic holdoff_run(input logic [15:0] len, input int expect_clk, input string name);
    int n = 0;
    holdoff_len = len;
    fire_rand();
    while (holdoff_o && n < 200) begin
      n++;
      step();
    end
    nvec++;
    if (n != expect_clk) begin
      nerr++;
      $display("FAIL %s: got %0d clk high expected %0d", name, n, expect_clk);
    end
  endtask

  task automatic test_holdoff();
    ce_mode = 1; m_tready = 1'b1;
    repeat (4) step();
    holdoff_run(16'd10, 20, "holdoff_10");
    repeat (3) step();
    holdoff_run(16'd0, 2, "holdoff_0");
    repeat (3) step();
    holdoff_len = 16'd4;
    fire_rand();
    repeat (4) step();
    holdoff_run(16'd4, 8, "holdoff_restart");
    repeat (20) step();
  endtask

  task automatic test_overflow();
    int n = 0;
    ce_mode = 0; m_tready = 1'b0;
    run_i = 1'b0; step(); step();
    run_i = 1'b1; step(); step();
    obs.delete();
    repeat (13) fire_rand();
    step(); step();
    nvec++;
    if (dead_o !== 1'b0) begin
      nerr++;
      $display("FAIL dead_at_13: got %b expected 0", dead_o);
    end
    fire_rand();
    step(); step();
    nvec++;
    if (dead_o !== 1'b1) begin
      nerr++;
      $display("FAIL dead_at_14: got %b expected 1", dead_o);
    end
    repeat (4) fire_rand();
    step();
    nvec++;
    if (overflow_o !== 16'd2 || overflow_o !== 16'(ov_m)) begin
      nerr++;
      $display("FAIL overflow_count: got %0d expected 2 (model %0d)", overflow_o, ov_m);
    end
    m_tready = 1'b1;
    while (obs.size() < 80 && n < 300) begin
      step();
      n++;
    end
    nvec++;
    if (n != 80) begin
      nerr++;
      $display("FAIL drain_back_to_back: got %0d clk expected 80", n);
    end
    for (int i = 0; i < 16 && obs.size() >= 80; i++) begin
      nvec++;
      if (obs[5*i][63:32] !== 32'(i) || obs[5*i+4][64] !== 1'b1) begin
        nerr++;
        $display("FAIL drain_evnum%0d: got ev=%0d last=%b expected ev=%0d last=1", i, obs[5*i][63:32], obs[5*i+4][64], i);
      end
    end
    fire_rand();
    wait_obs(85, "post_overflow");
    if (obs.size() >= 85) begin
      nvec++;
      if (obs[80][63:32] !== 32'd18) begin
        nerr++;
        $display("FAIL evnum_gap: got %0d expected 18", obs[80][63:32]);
      end
    end
  endtask

  task automatic test_run_cycle();
    ce_mode = 0; m_tready = 1'b1;
    repeat (5) step();
    obs.delete();
    run_i = 1'b0; step(); step();
    fire_rand();
    repeat (10) step();
    nvec++;
    if (obs.size() != 0 || overflow_o !== 16'd2) begin
      nerr++;
      $display("FAIL run_low_trig: got beats=%0d ovf=%0d expected 0 beats ovf=2", obs.size(), overflow_o);
    end
    run_i = 1'b1; step(); step();
    fire_rand();
    wait_obs(5, "run_restart");
    if (obs.size() >= 5) begin
      nvec++;
      if (obs[0] !== {1'b0, 32'd0, 32'd1}) begin
        nerr++;
        $display("FAIL run_restart_hdr: got %h expected %h", obs[0], {1'b0, 32'd0, 32'd1});
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int seen = 0;
    logic [63:0] m1;
    ce_mode = 0; m_tready = 1'b0;
    repeat (3) step();
    m1 = {$urandom, $urandom};
    fire({$urandom, $urandom}, m1, {$urandom, $urandom}, {$urandom, $urandom});
    while (!m_tvalid && k < 20) begin
      step();
      k++;
    end
    m_tready = 1'b1; step(); step();
    m_tready = 1'b0;
    nvec++;
    if (m_tvalid !== 1'b1 || m_tdata !== m1) begin
      nerr++;
      $display("FAIL at_m1: got valid=%b data=%h expected 1 %h", m_tvalid, m_tdata, m1);
    end
    rst_i = 1'b1;
    step();
    nvec++;
    if (m_tvalid !== 1'b0 || dead_o !== 1'b1 || overflow_o !== 16'd0) begin
      nerr++;
      $display("FAIL reset_mid: got valid=%b dead=%b ovf=%0d expected 0 1 0", m_tvalid, dead_o, overflow_o);
    end
    rst_i = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_tvalid) seen++;
    end
    nvec++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL reset_flush: got %0d valid clk expected 0", seen);
    end
  endtask

  task automatic test_random();
    int n = 0;
    ce_mode = 2; rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      holdoff_len = 16'($urandom_range(0, 5));
      fire_rand();
      repeat ($urandom_range(0, 3)) step();
    end
    rand_ready = 1'b0; m_tready = 1'b1;
    while (sb.size() > 0 && n < 2000) begin
      step();
      n++;
    end
    step();
    nvec++;
    if (sb.size() != 0 || m_tvalid !== 1'b0) begin
      nerr++;
      $display("FAIL random_drain: got pending=%0d valid=%b expected 0 0", sb.size(), m_tvalid);
    end
    nvec++;
    if (overflow_o !== 16'(ov_m)) begin
      nerr++;
      $display("FAIL random_overflow: got %0d expected %0d", overflow_o, ov_m);
    end
  endtask

  initial begin
    rst_i = 1'b1; ce_i = 1'b1; run_i = 1'b0; trig_i = 1'b0; m_tready = 1'b1;
    holdoff_len = 16'd1;
    for (int i = 0; i < 4; i++) meta_v[i] = '0;
    test_reset();
    test_single();
    test_holdoff();
    test_overflow();
    test_run_cycle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
